multicycle_ctrl_fsm: RTL and testbench

//  Parametrised multicycle control unit for the 8-bit CPU; successor to the fixed 3-state FETCH/EXECUTE/WRITEBACK controller.

---
 rtl/cpu_ctrl_pkg.sv | 50 +++++
 rtl/ctrl_alu_decode.sv | 72 +++++++
 rtl/multicycle_ctrl_fsm.sv | 147 ++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Opcode map, ALU op codes, PC source codes and FSM state encoding
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  localparam logic [3:0] OP_ADDI = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUBI = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLTI = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd8;
  localparam logic [3:0] OP_LW   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BNE  = 4'd12;
  localparam logic [3:0] OP_BLT  = 4'd13;
  localparam logic [3:0] OP_JMP  = 4'd14;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_NAND = 4'd6;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_alu_decode.sv
// ============================================================================
// Module   : ctrl_alu_decode
// Brief    : Combinational opcode classifier feeding the multicycle control FSM
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_alu_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_src_imm,
  output logic                is_branch,
  output logic                is_jump,
  output logic                is_mem,
  output logic                is_load,
  output logic                is_halt,
  output logic                is_legal
);

  logic [3:0] op4;
  logic [3:0] alu_code;

  assign op4 = opcode[3:0];

  // Only the low 16 codes are defined; anything wider decodes as NOP.
  generate
    if (OPCODE_W > 4) begin : g_wide_opcode
      assign is_legal = ~|opcode[OPCODE_W-1:4];
    end else begin : g_narrow_opcode
      assign is_legal = 1'b1;
    end
  endgenerate

  always_comb begin
    alu_code    = ALU_NOP;
    alu_src_imm = 1'b0;
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    is_mem      = 1'b0;
    is_load     = 1'b0;
    is_halt     = 1'b0;
    if (is_legal) begin
      case (op4)
        OP_ADDI: begin alu_code = ALU_ADD;  alu_src_imm = 1'b1; end
        OP_ADD:  alu_code = ALU_ADD;
        OP_SUBI: begin alu_code = ALU_SUB;  alu_src_imm = 1'b1; end
        OP_SUB:  alu_code = ALU_SUB;
        OP_SLT:  alu_code = ALU_SLT;
        OP_SLTI: begin alu_code = ALU_SLT;  alu_src_imm = 1'b1; end
        OP_SRA:  alu_code = ALU_SRA;
        OP_SLL:  alu_code = ALU_SLL;
        OP_NAND: alu_code = ALU_NAND;
        OP_LW:   begin alu_code = ALU_ADD; alu_src_imm = 1'b1; is_mem = 1'b1; is_load = 1'b1; end
        OP_SW:   begin alu_code = ALU_ADD; alu_src_imm = 1'b1; is_mem = 1'b1; end
        OP_BEQ, OP_BNE, OP_BLT: begin alu_code = ALU_SUB; is_branch = 1'b1; end
        OP_JMP:  is_jump = 1'b1;
        OP_HLT:  is_halt = 1'b1;
        default: alu_code = ALU_NOP;
      endcase
    end
  end

  assign alu_op = ALUOP_W'(alu_code);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Brief    : Multicycle control unit (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 4,
  parameter int ALUOP_W       = 4,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                alu_neg,
  input  logic                mem_ready,
  input  logic                resume,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_src_imm,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                wb_sel_mem,
  output logic                halted,
  output logic [2:0]          state_o
);

  state_t state, next_state;

  logic [ALUOP_W-1:0] dec_alu_op;
  logic dec_imm, is_branch, is_jump, is_mem, is_load, is_halt, is_legal;
  logic ready, branch_taken;
  logic [3:0] op4;

  ctrl_alu_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decode (
    .opcode      (opcode),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_imm),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .is_mem      (is_mem),
    .is_load     (is_load),
    .is_halt     (is_halt),
    .is_legal    (is_legal)
  );

  assign ready = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
  assign op4   = opcode[3:0];

  assign branch_taken = ((op4 == OP_BEQ) &&  alu_zero) ||
                        ((op4 == OP_BNE) && !alu_zero) ||
                        ((op4 == OP_BLT) &&  alu_neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    alu_op      = '0;
    alu_src_imm = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_INC;
    reg_write   = 1'b0;
    wb_sel_mem  = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        if (is_halt)        next_state = HALT;
        else if (!is_legal) next_state = FETCH;
        else                next_state = EXECUTE;
      end
      EXECUTE: begin
        alu_op      = dec_alu_op;
        alu_src_imm = dec_imm;
        if (is_branch) begin
          pc_write   = branch_taken;
          pc_src     = PC_BRANCH;
          next_state = FETCH;
        end else if (is_jump) begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          next_state = FETCH;
        end else if (is_mem) begin
          next_state = MEMORY;
        end else begin
          next_state = WRITEBACK;
        end
      end
      MEMORY: begin
        mem_read  = is_mem &&  is_load;
        mem_write = is_mem && !is_load;
        if (ready) next_state = (is_mem && is_load) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        reg_write  = 1'b1;
        wb_sel_mem = is_load;
        next_state = FETCH;
      end
      HALT: begin
        halted = 1'b1;
        if (resume) next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
    // Reset must silence requests immediately, not at the next edge.
    if (!rst_n) begin
      alu_op      = '0;
      alu_src_imm = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_INC;
      reg_write   = 1'b0;
      wb_sel_mem  = 1'b0;
      halted      = 1'b0;
    end
  end

  assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// ============================================================================
// Module   : tb_multicycle_ctrl_fsm
// Brief    : Directed vector bench for the multicycle control FSM
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = OP_ADD;
  logic       alu_zero = 1'b0, alu_neg = 1'b0, mem_ready = 1'b1, resume = 1'b0;
  logic [3:0] alu_op;
  logic       alu_src_imm, mem_read, mem_write, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, wb_sel_mem, halted;
  logic [2:0] state_o;

  // second instance: no handshake, 5-bit opcodes, mem_ready tied low
  logic [4:0] opcode2 = 5'd1;
  logic [3:0] alu_op_n;
  logic       alu_src_imm_n, mem_read_n, mem_write_n, ir_write_n, pc_write_n;
  logic [1:0] pc_src_n;
  logic       reg_write_n, wb_sel_mem_n, halted_n;
  logic [2:0] state_n;

  multicycle_ctrl_fsm #(.OPCODE_W(4), .ALUOP_W(4), .MEM_HANDSHAKE(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .mem_ready(mem_ready), .resume(resume), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .wb_sel_mem(wb_sel_mem), .halted(halted),
    .state_o(state_o)
  );

  multicycle_ctrl_fsm #(.OPCODE_W(5), .ALUOP_W(4), .MEM_HANDSHAKE(0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .opcode(opcode2), .alu_zero(1'b0), .alu_neg(1'b0),
    .mem_ready(1'b0), .resume(1'b0), .alu_op(alu_op_n), .alu_src_imm(alu_src_imm_n),
    .mem_read(mem_read_n), .mem_write(mem_write_n), .ir_write(ir_write_n), .pc_write(pc_write_n),
    .pc_src(pc_src_n), .reg_write(reg_write_n), .wb_sel_mem(wb_sel_mem_n), .halted(halted_n),
    .state_o(state_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       n;
    logic [3:0] aop;
    logic       imm;
    logic       pcw;
    logic [1:0] pcs;
    state_t     nxt;
  } vec_t;

  vec_t vecs[19];
  int   cyc;
  int   waits;

  initial begin
    vecs[0]  = '{OP_ADDI, 1'b0, 1'b0, ALU_ADD,  1'b1, 1'b0, PC_INC,    WRITEBACK};
    vecs[1]  = '{OP_ADD,  1'b0, 1'b0, ALU_ADD,  1'b0, 1'b0, PC_INC,    WRITEBACK};
    vecs[2]  = '{OP_SUBI, 1'b0, 1'b0, ALU_SUB,  1'b1, 1'b0, PC_INC,    WRITEBACK};
    vecs[3]  = '{OP_SUB,  1'b1, 1'b0, ALU_SUB,  1'b0, 1'b0, PC_INC,    WRITEBACK};
    vecs[4]  = '{OP_SLT,  1'b0, 1'b1, ALU_SLT,  1'b0, 1'b0, PC_INC,    WRITEBACK};
    vecs[5]  = '{OP_SLTI, 1'b0, 1'b0, ALU_SLT,  1'b1, 1'b0, PC_INC,    WRITEBACK};
    vecs[6]  = '{OP_SRA,  1'b0, 1'b0, ALU_SRA,  1'b0, 1'b0, PC_INC,    WRITEBACK};
    vecs[7]  = '{OP_SLL,  1'b0, 1'b0, ALU_SLL,  1'b0, 1'b0, PC_INC,    WRITEBACK};
    vecs[8]  = '{OP_NAND, 1'b0, 1'b0, ALU_NAND, 1'b0, 1'b0, PC_INC,    WRITEBACK};
    vecs[9]  = '{OP_LW,   1'b0, 1'b0, ALU_ADD,  1'b1, 1'b0, PC_INC,    MEMORY};
    vecs[10] = '{OP_SW,   1'b0, 1'b0, ALU_ADD,  1'b1, 1'b0, PC_INC,    MEMORY};
    vecs[11] = '{OP_BEQ,  1'b1, 1'b0, ALU_SUB,  1'b0, 1'b1, PC_BRANCH, FETCH};
    vecs[12] = '{OP_BEQ,  1'b0, 1'b1, ALU_SUB,  1'b0, 1'b0, PC_BRANCH, FETCH};
    vecs[13] = '{OP_BNE,  1'b0, 1'b0, ALU_SUB,  1'b0, 1'b1, PC_BRANCH, FETCH};
    vecs[14] = '{OP_BNE,  1'b1, 1'b0, ALU_SUB,  1'b0, 1'b0, PC_BRANCH, FETCH};
    vecs[15] = '{OP_BLT,  1'b0, 1'b1, ALU_SUB,  1'b0, 1'b1, PC_BRANCH, FETCH};
    vecs[16] = '{OP_BLT,  1'b1, 1'b0, ALU_SUB,  1'b0, 1'b0, PC_BRANCH, FETCH};
    vecs[17] = '{OP_JMP,  1'b0, 1'b0, ALU_NOP,  1'b0, 1'b1, PC_JUMP,   FETCH};
    vecs[18] = '{OP_JMP,  1'b1, 1'b1, ALU_NOP,  1'b0, 1'b1, PC_JUMP,   FETCH};

    // reset: everything silent even though FETCH with mem_ready=1
    tick(); tick();
    chk("rst_state", state_o, FETCH);
    chk("rst_outs", {alu_op, alu_src_imm, mem_read, mem_write, ir_write, pc_write,
                     pc_src, reg_write, wb_sel_mem, halted}, 0);

    // release, then add: F D E W F
    rst_n = 1'b1;
    #1;
    chk("rel_fetch", {mem_read, ir_write, pc_write, pc_src}, {1'b1, 1'b1, 1'b1, 2'd0});
    tick();
    chk("add_decode", state_o, DECODE);
    chk("add_decode_outs", {mem_read, ir_write, pc_write, reg_write}, 0);
    tick();
    chk("add_exec_state", state_o, EXECUTE);
    chk("add_exec_aluop", alu_op, ALU_ADD);
    tick();
    chk("add_wb_state", state_o, WRITEBACK);
    chk("add_wb_outs", {reg_write, wb_sel_mem}, 2'b10);
    tick();
    chk("add_back_fetch", state_o, FETCH);

    // table-driven EXECUTE decode
    for (int i = 0; i < 19; i++) begin
      opcode = vecs[i].op; alu_zero = vecs[i].z; alu_neg = vecs[i].n; mem_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_start", i), state_o, FETCH);
      tick(); tick();
      chk($sformatf("v%0d_exec", i), state_o, EXECUTE);
      chk($sformatf("v%0d_alu_op", i), alu_op, vecs[i].aop);
      chk($sformatf("v%0d_imm", i), alu_src_imm, vecs[i].imm);
      chk($sformatf("v%0d_pc_write", i), pc_write, vecs[i].pcw);
      chk($sformatf("v%0d_pc_src", i), pc_src, vecs[i].pcs);
      tick();
      chk($sformatf("v%0d_next", i), state_o, vecs[i].nxt);
      for (int k = 0; k < 4 && state_o != FETCH; k++) tick();
      chk($sformatf("v%0d_drain", i), state_o, FETCH);
    end
    alu_zero = 1'b0; alu_neg = 1'b0;

    // lw with 3 wait cycles in MEMORY
    opcode = OP_LW; mem_ready = 1'b1; cyc = 0; waits = 0;
    tick(); tick(); tick(); cyc = 3;
    chk("lw_mem_state", state_o, MEMORY);
    mem_ready = 1'b0;
    repeat (3) begin
      #1;
      if (mem_read && !mem_write) waits++;
      tick(); cyc++;
    end
    chk("lw_wait_reads", waits, 3);
    chk("lw_still_mem", state_o, MEMORY);
    mem_ready = 1'b1;
    #1;
    chk("lw_mem_read_last", {mem_read, mem_write}, 2'b10);
    tick(); cyc++;
    chk("lw_wb", {state_o, reg_write, wb_sel_mem}, {WRITEBACK, 2'b11});
    tick(); cyc++;
    chk("lw_fetch", state_o, FETCH);
    chk("lw_total_cycles", cyc, 8);

    // resume outside HALT is ignored; stalled FETCH holds mem_read only
    mem_ready = 1'b0; resume = 1'b1;
    #1;
    chk("stall_outs", {mem_read, ir_write, pc_write}, 3'b100);
    tick();
    chk("stall_resume_ignored", state_o, FETCH);
    resume = 1'b0;

    // HLT: HALT on cycle 3, held 10 cycles, resume -> FETCH
    opcode = OP_HLT; mem_ready = 1'b1;
    tick(); tick();
    chk("hlt_state", state_o, HALT);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("hlt_hold%0d", k), {halted, alu_op, mem_read, mem_write, ir_write,
                                         pc_write, reg_write, state_o}, {1'b1, 9'd0, HALT});
      tick();
    end
    resume = 1'b1;
    tick();
    chk("hlt_resume", {state_o, halted}, {FETCH, 1'b0});
    resume = 1'b0;

    // sw interrupted by reset while waiting in MEMORY
    opcode = OP_SW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    chk("sw_mem_write", {state_o, mem_read, mem_write}, {MEMORY, 2'b01});
    tick();
    chk("sw_stall", {state_o, mem_write}, {MEMORY, 1'b1});
    #2;
    rst_n = 1'b0;
    opcode2 = 5'(OP_SW);
    #1;
    chk("sw_rst_drop", {mem_write, reg_write, pc_write, state_o}, {3'b000, FETCH});
    tick();
    rst_n = 1'b1;
    #1;
    chk("after_rst_fetch", state_o, FETCH);

    // no-handshake instance: sw completes with mem_ready tied low
    chk("nh_fetch", {state_n, mem_read_n, ir_write_n, pc_write_n}, {FETCH, 3'b111});
    tick();
    chk("nh_decode", state_n, DECODE);
    tick();
    chk("nh_exec", state_n, EXECUTE);
    tick();
    chk("nh_mem", {state_n, mem_write_n, mem_read_n}, {MEMORY, 2'b10});
    tick();
    chk("nh_sw_done", state_n, FETCH);
    chk("main_still_stalled", state_o, FETCH);

    // illegal 5-bit opcode behaves as NOP: DECODE straight back to FETCH
    opcode2 = 5'h10;
    tick();
    chk("nh_ill_decode", state_n, DECODE);
    tick();
    chk("nh_ill_fetch", {state_n, reg_write_n}, {FETCH, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
